gate_truth_checker: RTL and testbench



---
 rtl/gate_pkg.sv | 18 +
 rtl/gate_settle_timer.sv | 28 ++
 rtl/gate_truth_checker.sv | 128 ++++++++++++
 tb/tb_gate_truth_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared encodings and reference truth tables for the 2-input gate checker.
package gate_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

    // Settle counter width; SETTLE is limited to 1..15.
    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle time before each sample.
import gate_pkg::*;

module gate_settle_timer (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero_c
);

    logic [SETTLE_W-1:0] cnt;

    // Load wins over decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero_c) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector into a gate under test, samples q after a settle
// time and scores it against an expected truth table.
import gate_pkg::*;

module gate_truth_checker #(
    parameter int unsigned             N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECT = TT_OR,
    parameter int unsigned             SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            q,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_seen
);

    localparam int unsigned         CNT_W       = N_IN + 1;
    localparam logic [N_IN-1:0]     LAST_VEC    = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_d;
    logic              busy_d, done_d, pass_d, fail_seen_d;
    logic [N_IN:0]     err_count_d;
    logic [N_IN-1:0]   fail_vec_d;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              mismatch;

    gate_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (SETTLE_LOAD),
        .zero_c   (tmr_zero)
    );

    // Unknown q is scored as a mismatch.
    assign mismatch = (q !== EXPECT[vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_seen <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec       <= vec_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_count_d;
            fail_vec  <= fail_vec_d;
            fail_seen <= fail_seen_d;
        end
    end

    // Next state and next register values; done/pass are set on entry to DONE.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        err_count_d = err_count;
        fail_vec_d  = fail_vec;
        fail_seen_d = fail_seen;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    vec_d       = '0;
                    err_count_d = '0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    tmr_load    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_zero) begin
                    state_d = S_CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count + CNT_W'(1);
                    if (!fail_seen) begin
                        fail_vec_d  = vec;
                        fail_seen_d = 1'b1;
                    end
                end
                if (vec == LAST_VEC) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    vec_d    = vec + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: default instance with selectable gate
// model on q, plus a SETTLE=3 instance driving an OR gate.
module tb_gate_truth_checker;
    import gate_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] vec_a, vec_b, fvec_a, fvec_b;
    logic [2:0] err_a, err_b;
    logic       q_a, q_b, busy_a, busy_b, done_a, done_b;
    logic       pass_a, pass_b, fseen_a, fseen_b;

    int mode = 0;  // 0: OR gate, 1: stuck at 0, 2: AND gate
    int n_cmp = 0, n_fail = 0;
    int vec_log [0:31];
    int done_cyc, done_cyc2, n_done;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       q_a = 1'b0;
            2:       q_a = &vec_a;
            default: q_a = |vec_a;
        endcase
    end
    assign q_b = |vec_b;

    gate_truth_checker #(.N_IN(2), .EXPECT(TT_OR), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec(vec_a), .q(q_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_vec(fvec_a), .fail_seen(fseen_a)
    );

    gate_truth_checker #(.N_IN(2), .EXPECT(TT_OR), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec(vec_b), .q(q_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_vec(fvec_b), .fail_seen(fseen_b)
    );

    // Start pulse in cycle 0, then log vec and done for ncyc cycles (sampled at negedge).
    task automatic run_sweep(input bit use_b, input int ncyc, input int re1, input int re2,
                             input bit hold);
        logic s, d;
        done_cyc = -1; done_cyc2 = -1; n_done = 0;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            s = hold || (c == re1) || (c == re2);
            if (use_b) start_b = s; else start_a = s;
            vec_log[c] = use_b ? int'(vec_b) : int'(vec_a);
            d = use_b ? done_b : done_a;
            if (d) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                else if (done_cyc2 < 0) done_cyc2 = c;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({busy_a, done_a, pass_a, err_a, fvec_a, fseen_a, vec_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected all zero",
                     {busy_a, done_a, pass_a, err_a, fvec_a, fseen_a, vec_a});
        end
        n_cmp++;
        if ({busy_b, done_b, pass_b, err_b, fvec_b, fseen_b, vec_b} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected all zero",
                     {busy_b, done_b, pass_b, err_b, fvec_b, fseen_b, vec_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_or_gate();
        mode = 0;
        run_sweep(1'b0, 12, -1, -1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            int exp_v;
            exp_v = (c <= 8) ? (c - 1) / 2 : 3;
            n_cmp++;
            if (vec_log[c] !== exp_v) begin
                n_fail++;
                $display("FAIL or_vec cycle %0d: got %0d expected %0d", c, vec_log[c], exp_v);
            end
        end
        n_cmp++;
        if (done_cyc !== 9 || n_done !== 1) begin
            n_fail++;
            $display("FAIL or_done: got cycle %0d count %0d expected cycle 9 count 1", done_cyc, n_done);
        end
        n_cmp++;
        if ({pass_a, err_a, fseen_a, busy_a} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL or_result: got pass %b err %0d seen %b busy %b expected 1 0 0 0",
                     pass_a, err_a, fseen_a, busy_a);
        end
    endtask

    task automatic test_stuck_low();
        mode = 1;
        run_sweep(1'b0, 12, -1, -1, 1'b0);
        n_cmp++;
        if ({pass_a, err_a, fvec_a, fseen_a} !== {1'b0, 3'd3, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL stuck_result: got pass %b err %0d fvec %b seen %b expected 0 3 01 1",
                     pass_a, err_a, fvec_a, fseen_a);
        end
        n_cmp++;
        if (done_cyc !== 9) begin
            n_fail++;
            $display("FAIL stuck_done: got %0d expected 9", done_cyc);
        end
    endtask

    task automatic test_and_gate();
        mode = 2;
        run_sweep(1'b0, 12, -1, -1, 1'b0);
        n_cmp++;
        if ({pass_a, err_a, fvec_a, fseen_a} !== {1'b0, 3'd2, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL and_result: got pass %b err %0d fvec %b seen %b expected 0 2 01 1",
                     pass_a, err_a, fvec_a, fseen_a);
        end
    endtask

    task automatic test_settle3();
        run_sweep(1'b1, 20, -1, -1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            int exp_v;
            exp_v = (c <= 16) ? (c - 1) / 4 : 3;
            n_cmp++;
            if (vec_log[c] !== exp_v) begin
                n_fail++;
                $display("FAIL s3_vec cycle %0d: got %0d expected %0d", c, vec_log[c], exp_v);
            end
        end
        n_cmp++;
        if (done_cyc !== 17 || n_done !== 1) begin
            n_fail++;
            $display("FAIL s3_done: got cycle %0d count %0d expected cycle 17 count 1", done_cyc, n_done);
        end
        n_cmp++;
        if ({pass_b, err_b, fseen_b} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL s3_result: got pass %b err %0d seen %b expected 1 0 0", pass_b, err_b, fseen_b);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        mode = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b1 || vec_a !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_pre: got busy %b vec %0d expected 1 1", busy_a, vec_a);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, pass_a, err_a, fvec_a, fseen_a, vec_a} !== 11'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected all zero",
                     {busy_a, done_a, pass_a, err_a, fvec_a, fseen_a, vec_a});
        end
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_a) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL mid_nodone: got %0d pulses expected 0", seen_done);
        end
        run_sweep(1'b0, 12, -1, -1, 1'b0);
        n_cmp++;
        if (done_cyc !== 9 || pass_a !== 1'b1 || err_a !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_fresh: got done %0d pass %b err %0d expected 9 1 0", done_cyc, pass_a, err_a);
        end
    endtask

    task automatic test_start_ignored();
        mode = 0;
        run_sweep(1'b0, 20, 3, 5, 1'b0);
        n_cmp++;
        if (n_done !== 1 || done_cyc !== 9) begin
            n_fail++;
            $display("FAIL ign_done: got count %0d cycle %0d expected 1 9", n_done, done_cyc);
        end
        n_cmp++;
        if ({pass_a, err_a, fseen_a, vec_a} !== {1'b1, 3'd0, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL ign_result: got pass %b err %0d seen %b vec %0d expected 1 0 0 3",
                     pass_a, err_a, fseen_a, vec_a);
        end
    endtask

    task automatic test_start_held();
        mode = 0;
        run_sweep(1'b0, 24, -1, -1, 1'b1);
        n_cmp++;
        if (n_done !== 2 || done_cyc !== 9 || done_cyc2 !== 19) begin
            n_fail++;
            $display("FAIL held_done: got count %0d cycles %0d %0d expected 2 9 19",
                     n_done, done_cyc, done_cyc2);
        end
        for (int c = 0; c < 12; c++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_or_gate();
        test_stuck_low();
        test_and_gate();
        test_settle3();
        test_reset_mid();
        test_start_ignored();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
